// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter: FSM state encoding,
// data-length encoding, parity selection and the frame parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic [1:0] DBN_5 = 2'b00;
  localparam logic [1:0] DBN_6 = 2'b01;
  localparam logic [1:0] DBN_7 = 2'b10;
  localparam logic [1:0] DBN_8 = 2'b11;

  localparam logic PAR_ODD  = 1'b0;
  localparam logic PAR_EVEN = 1'b1;

  // Index of the last data bit (4..7) for a data_bit_num code.
  function automatic logic [2:0] last_bit_idx(input logic [1:0] dbn);
    return 3'd4 + {1'b0, dbn};
  endfunction

  // Parity over only the bits that will actually be sent.
  function automatic logic parity_bit(input logic [7:0] data,
                                      input logic [1:0] dbn,
                                      input logic       ptype);
    logic [7:0] mask;
    mask = 8'hFF >> (2'd3 - dbn);
    return (^(data & mask)) ^ (ptype == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte write port of the transmit FIFO.
// Handshake: a byte transfers on the rising clk edge where wr_valid && wr_ready;
// wr_ready depends only on registered FIFO state, and wr_valid while !wr_ready
// drops the byte and raises the overflow flag.
interface uart_tx_fifo_if;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;

  modport master (output wr_valid, output wr_data, input  wr_ready);
  modport slave  (input  wr_valid, input  wr_data, output wr_ready);
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered occupancy; push_ready is derived from
// the occupancy register only, so it never reacts to a same-cycle pop.
module uart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           push_valid,
  input  logic [WIDTH-1:0]               push_data,
  output logic                           push_ready,
  input  logic                           pop,
  output logic [WIDTH-1:0]               pop_data,
  output logic [$clog2(DEPTH+1)-1:0]     level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    count_q, count_d;
  logic             push;

  always_comb begin
    push_ready = (count_q != LW'(DEPTH));
    push       = push_valid && push_ready;
    // Power-of-two depth: pointers wrap naturally.
    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    count_d    = count_q + LW'(push) - LW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign level    = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a byte FIFO: frame FSM, per-bit baud counter and
// LSB-first shifter; frame format is latched when a byte is popped.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [DIV_W-1:0]                  baud_div,
  input  logic [1:0]                        data_bit_num,
  input  logic                              stop_bit_num,
  input  logic                              parity_en,
  input  logic                              parity_type,
  input  logic                              tx_en,
  uart_tx_fifo_if.slave                     wr,
  input  logic                              ovf_clr,
  input  logic                              cts_n,
  output logic                              tx,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
  output logic                              overflow,
  output uart_state_e                       state_dbg
);

  uart_state_e      state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       idx_q, idx_d;
  logic [2:0]       last_idx_q, last_idx_d;
  logic             stop2_q, stop2_d;
  logic             par_en_q, par_en_d;
  logic             par_bit_q, par_bit_d;
  logic             stop_idx_q, stop_idx_d;
  logic             tx_q, tx_d;
  logic             overflow_q, overflow_d;

  logic             pop;
  logic [7:0]       pop_data;
  logic             fifo_ready;
  logic             bit_end;
  logic             start_ok;
  logic             launch;

  uart_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_valid (wr.wr_valid),
    .push_data  (wr.wr_data),
    .push_ready (fifo_ready),
    .pop        (pop),
    .pop_data   (pop_data),
    .level      (fifo_level)
  );

  assign wr.wr_ready = fifo_ready;

  always_comb begin
    // A new overflow event wins over a same-cycle clear.
    overflow_d = overflow_q;
    if (wr.wr_valid && !fifo_ready) overflow_d = 1'b1;
    else if (ovf_clr)               overflow_d = 1'b0;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    last_idx_d = last_idx_q;
    stop2_d    = stop2_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop_idx_d = stop_idx_q;
    tx_d       = tx_q;
    pop        = 1'b0;
    launch     = 1'b0;
    bit_end    = (cnt_q == div_q);
    start_ok   = tx_en && !cts_n && (fifo_level != '0);

    // The divisor is re-sampled at every reload, so a change lands on a bit boundary.
    if (state_q != ST_IDLE) begin
      if (bit_end) begin
        cnt_d = '0;
        div_d = baud_div;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: launch = start_ok;
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          idx_d   = 3'd0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (idx_q == last_idx_q) begin
            if (par_en_q) begin
              state_d = ST_PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d    = ST_STOP;
              tx_d       = 1'b1;
              stop_idx_d = 1'b0;
            end
          end else begin
            idx_d   = idx_q + 3'd1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d    = ST_STOP;
          tx_d       = 1'b1;
          stop_idx_d = 1'b0;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (stop2_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
          end else begin
            // Chain straight into the next frame so there is no idle gap.
            state_d = ST_IDLE;
            launch  = start_ok;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (launch) begin
      pop        = 1'b1;
      state_d    = ST_START;
      tx_d       = 1'b0;
      cnt_d      = '0;
      div_d      = baud_div;
      shift_d    = pop_data;
      last_idx_d = last_bit_idx(data_bit_num);
      stop2_d    = stop_bit_num;
      par_en_d   = parity_en;
      par_bit_d  = parity_bit(pop_data, data_bit_num, parity_type);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      div_q      <= '0;
      shift_q    <= '0;
      idx_q      <= '0;
      last_idx_q <= '0;
      stop2_q    <= 1'b0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop_idx_q <= 1'b0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      last_idx_q <= last_idx_d;
      stop2_q    <= stop2_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop_idx_q <= stop_idx_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx        = tx_q;
  assign busy      = (state_q != ST_IDLE);
  assign overflow  = overflow_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed frame scenarios plus randomized frame
// formats, compared cycle by cycle against a bit-list model of the line.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 4;
  localparam int DW    = 16;
  localparam int LW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          reset_n;
  logic [DW-1:0] baud_div;
  logic [1:0]    data_bit_num;
  logic          stop_bit_num, parity_en, parity_type, tx_en, ovf_clr, cts_n;
  logic          tx, busy, overflow;
  logic [LW-1:0] fifo_level;
  uart_state_e   state_dbg;

  uart_tx_fifo_if wif();

  uart_tx_fifo #(.FIFO_DEPTH(DEPTH), .DIV_W(DW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .baud_div     (baud_div),
    .data_bit_num (data_bit_num),
    .stop_bit_num (stop_bit_num),
    .parity_en    (parity_en),
    .parity_type  (parity_type),
    .tx_en        (tx_en),
    .wr           (wif),
    .ovf_clr      (ovf_clr),
    .cts_n        (cts_n),
    .tx           (tx),
    .busy         (busy),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [0:0] exp_q[$];

  // model copy of the frame format, kept apart from the pins so that
  // mid-frame pin scrambling does not disturb the expectation
  int   m_div;
  int   m_dbn;
  logic m_stop2, m_pen, m_ptype;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_bit(input logic b);
    for (int k = 0; k <= m_div; k++) exp_q.push_back(b);
  endtask

  task automatic model_frame(input logic [7:0] data);
    int nb, ones;
    logic b;
    nb   = 5 + m_dbn;
    ones = 0;
    push_bit(1'b0);
    for (int i = 0; i < nb; i++) begin
      b = (data >> i) & 8'd1;
      ones += int'(b);
      push_bit(b);
    end
    if (m_pen) begin
      if (m_ptype == PAR_EVEN) push_bit(1'((ones % 2) == 1));
      else                     push_bit(1'((ones % 2) == 0));
    end
    push_bit(1'b1);
    if (m_stop2) push_bit(1'b1);
  endtask

  // ---------------- drivers ----------------
  task automatic set_cfg(input int div, input int dbn, input logic s2, input logic pe, input logic pt);
    m_div = div; m_dbn = dbn; m_stop2 = s2; m_pen = pe; m_ptype = pt;
    baud_div = DW'(div); data_bit_num = 2'(dbn);
    stop_bit_num = s2; parity_en = pe; parity_type = pt;
  endtask

  task automatic write_byte(input logic [7:0] b);
    @(negedge clk);
    wif.wr_valid = 1'b1;
    wif.wr_data  = b;
    @(posedge clk);
    #1 wif.wr_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // Wait for the start bit, then compare every cycle against exp_q, then idle.
  task automatic run_frames(input int lat_exp, input bit scramble);
    int n, idx;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tx !== 1'b0 && n < 2000);
    check_val("start_latency", n, lat_exp);
    if (tx !== 1'b0) begin
      exp_q.delete();
      return;
    end
    idx = 0;
    while (exp_q.size() > 0) begin
      check_val("tx_bit", {31'd0, tx}, {31'd0, exp_q.pop_front()});
      check_val("busy_in_frame", {31'd0, busy}, 32'd1);
      if (scramble && idx == 3) begin
        data_bit_num = 2'($urandom_range(0, 3));
        stop_bit_num = 1'($urandom_range(0, 1));
        parity_en    = 1'($urandom_range(0, 1));
        parity_type  = 1'($urandom_range(0, 1));
      end
      idx++;
      @(negedge clk);
    end
    check_val("idle_tx", {31'd0, tx}, 32'd1);
    check_val("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] b;
    int n, bad, k;

    reset_n = 1'b0; tx_en = 1'b1; cts_n = 1'b0; ovf_clr = 1'b0;
    wif.wr_valid = 1'b0; wif.wr_data = '0;
    set_cfg(3, 3, 1'b0, 1'b0, PAR_ODD);
    do_reset();

    @(negedge clk);
    check_val("rst_tx", {31'd0, tx}, 32'd1);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_wr_ready", {31'd0, wif.wr_ready}, 32'd1);
    check_val("rst_level", 32'(fifo_level), 32'd0);
    check_val("rst_overflow", {31'd0, overflow}, 32'd0);
    check_val("rst_state", 32'(state_dbg), 32'(ST_IDLE));

    // 8N1, div 3, 0xA5; format pins scrambled mid-frame must not matter
    set_cfg(3, 3, 1'b0, 1'b0, PAR_ODD);
    model_frame(8'hA5);
    write_byte(8'hA5);
    run_frames(2, 1'b1);

    // 7E2, div 0, 0x03
    set_cfg(0, 2, 1'b1, 1'b1, PAR_EVEN);
    model_frame(8'h03);
    write_byte(8'h03);
    run_frames(2, 1'b1);

    // tx_en low holds a queued byte
    set_cfg(1, 1, 1'b0, 1'b1, PAR_ODD);
    tx_en = 1'b0;
    write_byte(8'h5C);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check_val("tx_en_block", bad, 0);
    check_val("tx_en_level", 32'(fifo_level), 32'd1);
    model_frame(8'h5C);
    tx_en = 1'b1;
    run_frames(1, 1'b0);

    // fill to depth, overflow on the fifth write, clear behaviour
    set_cfg(2, 3, 1'b0, 1'b1, PAR_EVEN);
    cts_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom);
      model_frame(b);
      write_byte(b);
      check_val("fill_level", 32'(fifo_level), 32'(i + 1));
      check_val("fill_ready", {31'd0, wif.wr_ready}, (i + 1 < DEPTH) ? 32'd1 : 32'd0);
    end
    check_val("pre_ovf", {31'd0, overflow}, 32'd0);
    write_byte(8'hEE);
    check_val("ovf_set", {31'd0, overflow}, 32'd1);
    check_val("ovf_level", 32'(fifo_level), 32'(DEPTH));
    @(negedge clk);
    check_val("ovf_sticky", {31'd0, overflow}, 32'd1);
    ovf_clr = 1'b1;
    @(posedge clk);
    #1 ovf_clr = 1'b0;
    check_val("ovf_clr", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    ovf_clr = 1'b1;
    wif.wr_valid = 1'b1;
    wif.wr_data = 8'h11;
    @(posedge clk);
    #1 ovf_clr = 1'b0;
    wif.wr_valid = 1'b0;
    check_val("ovf_clr_vs_set", {31'd0, overflow}, 32'd1);
    ovf_clr = 1'b1;
    @(posedge clk);
    #1 ovf_clr = 1'b0;
    check_val("ovf_clr2", {31'd0, overflow}, 32'd0);
    // only the first DEPTH bytes are sent, back to back
    @(negedge clk);
    cts_n = 1'b0;
    run_frames(1, 1'b0);

    // two 5N1 frames at div 1, no gap
    set_cfg(1, 0, 1'b0, 1'b0, PAR_ODD);
    cts_n = 1'b1;
    write_byte(8'h96);
    write_byte(8'h1B);
    model_frame(8'h96);
    model_frame(8'h1B);
    @(negedge clk);
    cts_n = 1'b0;
    run_frames(1, 1'b0);

    // cts_n raised during the first of three frames
    set_cfg(1, 3, 1'b0, 1'b0, PAR_ODD);
    cts_n = 1'b0;
    write_byte(8'h31);
    write_byte(8'h72);
    write_byte(8'hC4);
    check_val("cts_level", 32'(fifo_level), 32'd2);
    cts_n = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy !== 1'b0 && n < 200);
    check_val("cts_frame_end", n, 20);
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check_val("cts_hold", bad, 0);
    check_val("cts_hold_level", 32'(fifo_level), 32'd2);
    model_frame(8'h72);
    model_frame(8'hC4);
    cts_n = 1'b0;
    run_frames(1, 1'b0);

    // reset in the middle of the data bits
    set_cfg(2, 3, 1'b0, 1'b0, PAR_ODD);
    cts_n = 1'b1;
    write_byte(8'hFF);
    write_byte(8'h00);
    write_byte(8'h55);
    @(negedge clk);
    cts_n = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tx !== 1'b0 && n < 200);
    check_val("rst_mid_start", {31'd0, tx}, 32'd0);
    repeat (3 * (m_div + 1)) @(negedge clk);
    check_val("rst_mid_state", 32'(state_dbg), 32'(ST_DATA));
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check_val("rst_mid_tx", {31'd0, tx}, 32'd1);
    check_val("rst_mid_busy", {31'd0, busy}, 32'd0);
    check_val("rst_mid_level", 32'(fifo_level), 32'd0);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check_val("rst_mid_quiet", bad, 0);

    // random frame formats and payloads
    for (int it = 0; it < 10; it++) begin
      set_cfg($urandom_range(0, 4), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      k = $urandom_range(1, DEPTH);
      cts_n = 1'b1;
      for (int i = 0; i < k; i++) begin
        b = 8'($urandom);
        model_frame(b);
        write_byte(b);
      end
      check_val("rand_level", 32'(fifo_level), 32'(k));
      @(negedge clk);
      cts_n = 1'b0;
      run_frames(1, 1'b0);
      check_val("rand_empty", 32'(fifo_level), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
